// File: rtl/csr_access_arbiter.sv
// Round-robin arbiter sharing one CSR unit port between the core pipeline and the
// debug module; each granted access runs as a one-cycle read followed by a one-cycle commit.
module csr_access_arbiter #(
  parameter bit RO_CHECK = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic [11:0] core_addr_i,
  input  logic [31:0] core_data_i,
  input  logic [1:0]  core_op_i,
  output logic        core_ack_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,
  input  logic        dbg_req_i,
  input  logic [11:0] dbg_addr_i,
  input  logic [31:0] dbg_data_i,
  input  logic [1:0]  dbg_op_i,
  output logic        dbg_ack_o,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_err_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_data_o,
  output logic [1:0]  csr_op_o,
  output logic        csr_we_o,
  input  logic [31:0] csr_rdata_i
);

  typedef enum logic [1:0] {IDLE, READ, COMMIT} state_t;

  state_t      state_q;
  logic        gnt_dbg_q;
  logic        last_dbg_q;
  logic [11:0] csr_addr_q;
  logic [31:0] csr_data_q;
  logic [1:0]  csr_op_q;
  logic        csr_we_q;
  logic        core_ack_q, dbg_ack_q;
  logic        core_err_q, dbg_err_q;
  logic [31:0] core_rdata_q, dbg_rdata_q;

  logic pick_dbg;
  logic do_write;
  logic illegal;

  // Under contention the side that did not win last time gets the port.
  assign pick_dbg = dbg_req_i & (~core_req_i | ~last_dbg_q);

  assign do_write = (csr_op_q == 2'b00) |
                    (((csr_op_q == 2'b01) | (csr_op_q == 2'b10)) & (csr_data_q != 32'd0));
  assign illegal  = do_write & RO_CHECK & (csr_addr_q[11:10] == 2'b11);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      gnt_dbg_q    <= 1'b0;
      last_dbg_q   <= 1'b1;
      csr_addr_q   <= '0;
      csr_data_q   <= '0;
      csr_op_q     <= '0;
      csr_we_q     <= 1'b0;
      core_ack_q   <= 1'b0;
      dbg_ack_q    <= 1'b0;
      core_err_q   <= 1'b0;
      dbg_err_q    <= 1'b0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (core_req_i | dbg_req_i) begin
            gnt_dbg_q  <= pick_dbg;
            last_dbg_q <= pick_dbg;
            csr_addr_q <= pick_dbg ? dbg_addr_i : core_addr_i;
            csr_data_q <= pick_dbg ? dbg_data_i : core_data_i;
            csr_op_q   <= pick_dbg ? dbg_op_i   : core_op_i;
            state_q    <= READ;
          end
        end
        READ: begin
          // The old value is sampled here; the commit-cycle outputs are set up one edge early.
          csr_we_q <= do_write & ~illegal;
          if (gnt_dbg_q) begin
            dbg_ack_q   <= 1'b1;
            dbg_rdata_q <= csr_rdata_i;
            dbg_err_q   <= illegal;
          end else begin
            core_ack_q   <= 1'b1;
            core_rdata_q <= csr_rdata_i;
            core_err_q   <= illegal;
          end
          state_q <= COMMIT;
        end
        COMMIT: begin
          csr_addr_q   <= '0;
          csr_data_q   <= '0;
          csr_op_q     <= '0;
          csr_we_q     <= 1'b0;
          core_ack_q   <= 1'b0;
          dbg_ack_q    <= 1'b0;
          core_err_q   <= 1'b0;
          dbg_err_q    <= 1'b0;
          core_rdata_q <= '0;
          dbg_rdata_q  <= '0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign csr_addr_o   = csr_addr_q;
  assign csr_data_o   = csr_data_q;
  assign csr_op_o     = csr_op_q;
  assign csr_we_o     = csr_we_q;
  assign core_ack_o   = core_ack_q;
  assign core_rdata_o = core_rdata_q;
  assign core_err_o   = core_err_q;
  assign dbg_ack_o    = dbg_ack_q;
  assign dbg_rdata_o  = dbg_rdata_q;
  assign dbg_err_o    = dbg_err_q;

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Directed bench for csr_access_arbiter with a queue-based scoreboard per requester.
module tb_csr_access_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i, dbg_req_i;
  logic [11:0] core_addr_i, dbg_addr_i;
  logic [31:0] core_data_i, dbg_data_i;
  logic [1:0]  core_op_i, dbg_op_i;
  logic        core_ack_o, dbg_ack_o;
  logic [31:0] core_rdata_o, dbg_rdata_o;
  logic        core_err_o, dbg_err_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_data_o;
  logic [1:0]  csr_op_o;
  logic        csr_we_o;
  logic [31:0] csr_rdata_i;

  csr_access_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_data_i(core_data_i),
    .core_op_i(core_op_i), .core_ack_o(core_ack_o), .core_rdata_o(core_rdata_o),
    .core_err_o(core_err_o),
    .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_data_i(dbg_data_i),
    .dbg_op_i(dbg_op_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o),
    .dbg_err_o(dbg_err_o),
    .csr_addr_o(csr_addr_o), .csr_data_o(csr_data_o), .csr_op_o(csr_op_o),
    .csr_we_o(csr_we_o), .csr_rdata_i(csr_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // CSR unit stand-in: 0xC00 behaves as a free-running cycle counter.
  function automatic logic [31:0] model_rd(input logic [11:0] a, input int c);
    if (a == 12'hC00) return 32'(c);
    if (a == 12'h340) return 32'h0000_1234;
    return {20'hC5A00, a};
  endfunction

  assign csr_rdata_i = model_rd(csr_addr_o, cyc);

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        we;
    logic [31:0] wdata;
    int          cyc;
  } exp_t;

  exp_t core_q[$];
  exp_t dbg_q[$];
  int nvec = 0;
  int nmis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_entry(input string side, input exp_t e, input logic [31:0] rd,
                           input logic err);
    check({side, "_rdata"}, rd, e.rdata);
    check({side, "_err"}, 32'(err), 32'(e.err));
    check({side, "_we"}, 32'(csr_we_o), 32'(e.we));
    check({side, "_ack_cycle"}, 32'(cyc), 32'(e.cyc));
    if (e.we) check({side, "_wdata"}, csr_data_o, e.wdata);
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    check("we_outside_commit", 32'(csr_we_o & ~(core_ack_o | dbg_ack_o)), 32'd0);
    if (core_ack_o) begin
      if (core_q.size() == 0) check("core_unexpected_ack", 32'd1, 32'd0);
      else begin
        e = core_q.pop_front();
        chk_entry("core", e, core_rdata_o, core_err_o);
      end
    end else begin
      check("core_rdata_idle", core_rdata_o, 32'd0);
      check("core_err_idle", 32'(core_err_o), 32'd0);
    end
    if (dbg_ack_o) begin
      if (dbg_q.size() == 0) check("dbg_unexpected_ack", 32'd1, 32'd0);
      else begin
        e = dbg_q.pop_front();
        chk_entry("dbg", e, dbg_rdata_o, dbg_err_o);
      end
    end else begin
      check("dbg_rdata_idle", dbg_rdata_o, 32'd0);
      check("dbg_err_idle", 32'(dbg_err_o), 32'd0);
    end
  end

  task automatic drain(input int bound, input bit keep);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_i);
      #1;
      if (!keep) begin
        if (core_ack_o) core_req_i = 1'b0;
        if (dbg_ack_o)  dbg_req_i  = 1'b0;
      end
      if (core_q.size() == 0 && dbg_q.size() == 0) return;
    end
    check("ack_timeout", 32'd1, 32'd0);
    core_q.delete();
    dbg_q.delete();
    core_req_i = 1'b0;
    dbg_req_i  = 1'b0;
  endtask

  task automatic go(input bit dbg, input logic [11:0] a, input logic [31:0] d,
                    input logic [1:0] op, input bit err, input bit we);
    exp_t e;
    @(negedge clk_i);
    e.rdata = model_rd(a, cyc + 1);
    e.err   = err;
    e.we    = we;
    e.wdata = d;
    e.cyc   = cyc + 2;
    if (dbg) begin
      dbg_addr_i = a; dbg_data_i = d; dbg_op_i = op; dbg_req_i = 1'b1;
      dbg_q.push_back(e);
    end else begin
      core_addr_i = a; core_data_i = d; core_op_i = op; core_req_i = 1'b1;
      core_q.push_back(e);
    end
    drain(20, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_i = 1'b1;
    core_req_i = 1'b0; core_addr_i = '0; core_data_i = '0; core_op_i = '0;
    dbg_req_i  = 1'b0; dbg_addr_i  = '0; dbg_data_i  = '0; dbg_op_i  = '0;
    repeat (2) @(negedge clk_i);
    check("rst_csr_addr", 32'(csr_addr_o), 32'd0);
    check("rst_csr_data", csr_data_o, 32'd0);
    check("rst_csr_op", 32'(csr_op_o), 32'd0);
    check("rst_csr_we", 32'(csr_we_o), 32'd0);
    check("rst_core_ack", 32'(core_ack_o), 32'd0);
    check("rst_dbg_ack", 32'(dbg_ack_o), 32'd0);
    rst_i = 1'b0;

    // Plain RW, read-only CSR write, zero-mask set/clear, RC with mask, read-only op.
    go(1'b0, 12'h340, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b1);
    go(1'b1, 12'hC00, 32'h0000_0055, 2'b00, 1'b1, 1'b0);
    go(1'b1, 12'hC00, 32'h0000_0000, 2'b01, 1'b0, 1'b0);
    go(1'b0, 12'h300, 32'h0000_0000, 2'b01, 1'b0, 1'b0);
    go(1'b0, 12'h300, 32'h0000_0008, 2'b10, 1'b0, 1'b1);
    go(1'b0, 12'h300, 32'hFFFF_FFFF, 2'b11, 1'b0, 1'b0);
    go(1'b1, 12'h7B0, 32'h0000_0003, 2'b01, 1'b0, 1'b1);

    // Contention out of reset with both lines held: core, dbg, core.
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0;
    @(negedge clk_i);
    core_addr_i = 12'h340; core_data_i = 32'd5; core_op_i = 2'b00; core_req_i = 1'b1;
    dbg_addr_i  = 12'h301; dbg_data_i  = 32'd9; dbg_op_i  = 2'b11; dbg_req_i  = 1'b1;
    e.rdata = 32'h1234; e.err = 1'b0; e.we = 1'b1; e.wdata = 32'd5; e.cyc = cyc + 2;
    core_q.push_back(e);
    e.rdata = model_rd(12'h301, 0); e.we = 1'b0; e.cyc = cyc + 5;
    dbg_q.push_back(e);
    e.rdata = 32'h1234; e.we = 1'b1; e.cyc = cyc + 8;
    core_q.push_back(e);
    drain(30, 1'b1);
    core_req_i = 1'b0;
    dbg_req_i  = 1'b0;

    // Asynchronous reset during READ abandons the access.
    @(negedge clk_i);
    @(negedge clk_i);
    core_addr_i = 12'h305; core_data_i = 32'd1; core_op_i = 2'b00; core_req_i = 1'b1;
    @(negedge clk_i);
    #1;
    check("read_phase_addr", 32'(csr_addr_o), 32'h305);
    check("read_phase_we", 32'(csr_we_o), 32'd0);
    rst_i = 1'b1;
    #1;
    check("async_rst_addr", 32'(csr_addr_o), 32'd0);
    check("async_rst_data", csr_data_o, 32'd0);
    check("async_rst_op", 32'(csr_op_o), 32'd0);
    check("async_rst_ack", 32'(core_ack_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    e.rdata = model_rd(12'h305, 0); e.err = 1'b0; e.we = 1'b1; e.wdata = 32'd1;
    e.cyc = cyc + 2;
    core_q.push_back(e);
    drain(20, 1'b0);

    repeat (3) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
